// File: rtl/cache_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : cache_arb_pkg
//  Description : Shared constants, width helpers and output word type for the
//                cache control-path arbitrated merge (arb_merge_rr_cache).
//  Contents    : ARB_FIXED / ARB_RR mode codes, id_width() helper, default
//                configuration widths, out_word_t {ch_id, data} word type.
//  Revision    : 1.0 - initial release
// ============================================================================
package cache_arb_pkg;

  // Arbitration mode codes for the ARB_MODE parameter
  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // Width of a channel id; never narrower than one bit
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Default configuration of the merge
  localparam int DEF_NUM_CH     = 4;
  localparam int DEF_DATA_WIDTH = 5;
  localparam int DEF_ID_W       = id_width(DEF_NUM_CH);

  // Output word of the default configuration: winning channel id plus payload
  typedef struct packed {
    logic [DEF_ID_W-1:0]       ch_id;
    logic [DEF_DATA_WIDTH-1:0] data;
  } out_word_t;

endpackage
`default_nettype wire

// File: rtl/cache_ch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : cache_ch_fifo
//  Description : Per-channel synchronous FIFO for the cache arbitrated merge.
//                Show-ahead: head always presents the oldest stored word.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                push, push_data - write request / payload (ignored when full)
//                pop             - remove head (ignored when empty)
//                head            - oldest stored word
//                full, empty     - occupancy flags (registered state only)
//  Revision    : 1.0 - initial release
// ============================================================================
module cache_ch_fifo #(
  parameter int DATA_WIDTH = 5,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic                  full,
  output logic                  empty
);

  // Pointers carry one extra bit so full and empty are distinguishable
  localparam int PW = $clog2(FIFO_DEPTH) + 1;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         fill;
  logic [AW-1:0]         wr_idx;
  logic [AW-1:0]         rd_idx;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic                  do_push;
  logic                  do_pop;

  assign fill    = wr_ptr - rd_ptr;
  assign full    = (fill == PW'(FIFO_DEPTH));
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  generate
    if (FIFO_DEPTH == 1) begin : g_single
      assign wr_idx = '0;
      assign rd_idx = '0;
    end else begin : g_multi
      // Depth is a power of two, so the low pointer bits wrap naturally
      assign wr_idx = wr_ptr[AW-1:0];
      assign rd_idx = rd_ptr[AW-1:0];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage needs no reset: the pointers alone define what is valid
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_idx] <= push_data;
  end

  assign head = mem[rd_idx];

endmodule
`default_nettype wire

// File: rtl/arb_merge_rr_cache.sv
`default_nettype none
// ============================================================================
//  Module      : arb_merge_rr_cache
//  Description : NUM_CH-input arbitrated merge for the cache control path.
//                Each channel feeds a small FIFO; a fixed-priority or
//                round-robin arbiter selects one non-empty FIFO per cycle into
//                a registered output carrying payload plus source channel id.
//  Ports       : clk, rst     - clock, synchronous active-high reset
//                i_drive      - per-channel valid (transfer on i_drive & o_free)
//                i_data       - channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//                o_free       - per-channel ready (channel FIFO not full)
//                o_driveNext  - output valid, held until consumed
//                o_data       - payload of current output word
//                o_chId       - source channel of o_data
//                i_freeNext   - downstream ready
//  Revision    : 1.0 - initial release
// ============================================================================
module arb_merge_rr_cache
  import cache_arb_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 5,
  parameter int FIFO_DEPTH = 2,
  parameter int ARB_MODE   = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            i_drive,
  input  logic [NUM_CH*DATA_WIDTH-1:0] i_data,
  output logic [NUM_CH-1:0]            o_free,
  output logic                         o_driveNext,
  output logic [DATA_WIDTH-1:0]        o_data,
  output logic [$clog2(NUM_CH)-1:0]    o_chId,
  input  logic                         i_freeNext
);

  localparam int ID_W = id_width(NUM_CH);
  // NUM_CH expressed one bit wider than an id, for modulo wrap compares
  localparam logic [ID_W:0] NUM_CH_X = (ID_W + 1)'(NUM_CH);

  typedef struct packed {
    logic [ID_W-1:0]       ch_id;
    logic [DATA_WIDTH-1:0] data;
  } word_t;

  logic [NUM_CH-1:0]     full;
  logic [NUM_CH-1:0]     empty;
  logic [NUM_CH-1:0]     push;
  logic [NUM_CH-1:0]     pop;
  logic [DATA_WIDTH-1:0] heads [NUM_CH];

  logic [NUM_CH-1:0]     req;
  logic [2*NUM_CH-1:0]   req2;
  logic [NUM_CH-1:0]     rot;
  logic [ID_W-1:0]       start;
  logic [ID_W-1:0]       offset;
  logic [ID_W:0]         sum;
  logic [ID_W:0]         inc;
  logic [ID_W-1:0]       winner;
  logic [ID_W-1:0]       ptr_next;
  logic                  any_req;
  logic                  load;

  logic                  out_valid;
  word_t                 out_q;
  logic [ID_W-1:0]       ptr;

  // --------------------------------------------------------------------------
  // Channel buffers
  // --------------------------------------------------------------------------
  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      // Ready depends only on FIFO state, so a full FIFO refuses a push even
      // when it is being popped in the same cycle.
      assign push[i] = i_drive[i] & ~full[i];
      assign pop[i]  = load & (winner == ID_W'(i));

      cache_ch_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
      ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push[i]),
        .push_data (i_data[i*DATA_WIDTH +: DATA_WIDTH]),
        .pop       (pop[i]),
        .head      (heads[i]),
        .full      (full[i]),
        .empty     (empty[i])
      );
    end
  endgenerate

  assign o_free = ~full;

  // --------------------------------------------------------------------------
  // Arbiter: rotate a doubled request vector so the search origin lands at
  // bit 0, priority-encode the lowest set bit, then rotate the result back.
  // Fixed priority is the same search with the origin pinned at channel 0.
  // --------------------------------------------------------------------------
  assign req     = ~empty;
  assign req2    = {req, req};
  assign any_req = |req;

  always_comb begin
    start  = (ARB_MODE == ARB_RR) ? ptr : '0;
    rot    = req2[start +: NUM_CH];
    offset = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (rot[k]) offset = ID_W'(k);
    end
    sum = {1'b0, start} + {1'b0, offset};
    if (sum >= NUM_CH_X) sum = sum - NUM_CH_X;
    winner = sum[ID_W-1:0];

    inc = {1'b0, winner} + (ID_W + 1)'(1);
    if (inc == NUM_CH_X) inc = '0;
    ptr_next = inc[ID_W-1:0];
  end

  // Reload whenever the output slot is empty or being consumed this cycle;
  // this gives back-to-back transfers with no bubble.
  assign load = (~out_valid | i_freeNext) & any_req;

  // --------------------------------------------------------------------------
  // Output register and round-robin pointer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_q     <= '0;
      ptr       <= '0;
    end else begin
      if (load) begin
        out_valid   <= 1'b1;
        out_q.ch_id <= winner;
        out_q.data  <= heads[winner];
        if (ARB_MODE == ARB_RR) ptr <= ptr_next;
      end else if (i_freeNext) begin
        // Payload is left untouched so o_data keeps the last word
        out_valid <= 1'b0;
      end
    end
  end

  assign o_driveNext = out_valid;
  assign o_data      = out_q.data;
  assign o_chId      = out_q.ch_id;

endmodule
`default_nettype wire

// File: tb/tb_arb_merge_rr_cache.sv
`default_nettype none
// ============================================================================
//  Module      : tb_arb_merge_rr_cache
//  Description : Self-checking bench for arb_merge_rr_cache. Two instances
//                (round-robin and fixed priority) share one stimulus stream
//                and are compared every cycle against a queue-based model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_arb_merge_rr_cache;

  localparam int N  = 4;
  localparam int DW = 5;
  localparam int D  = 2;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    drive = '0;
  logic [N*DW-1:0] data = '0;
  logic            free_next = 1'b0;

  logic [N-1:0]    free_r, free_f;
  logic            dn_r, dn_f;
  logic [DW-1:0]   data_r, data_f;
  logic [IW-1:0]   ch_r, ch_f;

  int errors = 0;
  int checks = 0;

  // Model state: index 0 = round-robin instance, 1 = fixed-priority instance
  logic [DW-1:0] q [2*N][$];
  logic          mv [2];
  logic [DW-1:0] md [2];
  logic [IW-1:0] mc [2];
  int            mp [2];

  always #5 clk = ~clk;

  arb_merge_rr_cache #(.NUM_CH(N), .DATA_WIDTH(DW), .FIFO_DEPTH(D), .ARB_MODE(1)) dut_rr (
    .clk(clk), .rst(rst), .i_drive(drive), .i_data(data), .o_free(free_r),
    .o_driveNext(dn_r), .o_data(data_r), .o_chId(ch_r), .i_freeNext(free_next)
  );

  arb_merge_rr_cache #(.NUM_CH(N), .DATA_WIDTH(DW), .FIFO_DEPTH(D), .ARB_MODE(0)) dut_fx (
    .clk(clk), .rst(rst), .i_drive(drive), .i_data(data), .o_free(free_f),
    .o_driveNext(dn_f), .o_data(data_f), .o_chId(ch_f), .i_freeNext(free_next)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock edge of the behavioural model, using the inputs seen at the edge
  task automatic model_edge();
    bit full_pre [N];
    bit found;
    int start, w, c;
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        for (int i = 0; i < N; i++) q[m*N+i].delete();
        mv[m] = 1'b0; md[m] = '0; mc[m] = '0; mp[m] = 0;
      end else begin
        for (int i = 0; i < N; i++) full_pre[i] = (q[m*N+i].size() >= D);
        found = 1'b0; w = 0;
        start = (m == 0) ? mp[m] : 0;
        for (int k = 0; k < N; k++) begin
          c = (start + k) % N;
          if (!found && q[m*N+c].size() > 0) begin found = 1'b1; w = c; end
        end
        if (found && (!mv[m] || free_next)) begin
          md[m] = q[m*N+w].pop_front();
          mc[m] = IW'(w);
          mv[m] = 1'b1;
          if (m == 0) mp[m] = (w + 1) % N;
        end else if (free_next) begin
          mv[m] = 1'b0;
        end
        for (int i = 0; i < N; i++)
          if (drive[i] && !full_pre[i]) q[m*N+i].push_back(data[i*DW +: DW]);
      end
    end
  endtask

  function automatic logic [N-1:0] model_free(input int m);
    logic [N-1:0] f;
    for (int i = 0; i < N; i++) f[i] = (q[m*N+i].size() < D);
    return f;
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("rr_valid", 32'(dn_r),   32'(mv[0]));
    check("rr_data",  32'(data_r), 32'(md[0]));
    check("rr_chid",  32'(ch_r),   32'(mc[0]));
    check("rr_free",  32'(free_r), 32'(model_free(0)));
    check("fx_valid", 32'(dn_f),   32'(mv[1]));
    check("fx_data",  32'(data_f), 32'(md[1]));
    check("fx_chid",  32'(ch_f),   32'(mc[1]));
    check("fx_free",  32'(free_f), 32'(model_free(1)));
  endtask

  initial begin
    int exp_id;
    int idx;
    bit saw3;
    bit acc;

    // Reset held for two cycles
    rst = 1'b1; drive = '0; data = '0; free_next = 1'b0;
    step();
    step();
    check("reset_free",  32'(free_r), 32'hF);
    check("reset_valid", 32'(dn_r),   32'h0);
    check("reset_data",  32'(data_r), 32'h0);
    check("reset_chid",  32'(ch_r),   32'h0);

    // Single word from channel 2
    rst = 1'b0; free_next = 1'b1;
    drive = 4'b0100; data = '0; data[2*DW +: DW] = 5'h15;
    step();
    drive = '0;
    step();
    check("single_valid", 32'(dn_r),   32'h1);
    check("single_data",  32'(data_r), 32'h15);
    check("single_chid",  32'(ch_r),   32'h2);
    check("single_fx_ch", 32'(ch_f),   32'h2);
    step();
    check("single_drop", 32'(dn_r), 32'h0);
    check("single_hold", 32'(data_r), 32'h15);

    // Round-robin fairness / fixed priority with all channels busy
    rst = 1'b1; step(); rst = 1'b0;
    drive = 4'b1111; free_next = 1'b1; data = 20'($urandom());
    step();
    exp_id = 0;
    for (int j = 0; j < 12; j++) begin
      data = 20'($urandom());
      step();
      check("rr_seq", 32'(ch_r), 32'(exp_id % N));
      check("fx_seq", 32'(ch_f), 32'h0);
      exp_id++;
    end
    // Channel 0 stops; fixed priority must eventually reach channel 3
    drive = 4'b1000;
    saw3 = 1'b0;
    for (int j = 0; j < 10; j++) begin
      data = 20'($urandom());
      step();
      if (dn_f && ch_f == 2'd3) saw3 = 1'b1;
    end
    check("fx_ch3_served", 32'(saw3), 32'h1);

    // Backpressure: channel 1 sends 1,2,3 while downstream stalls
    drive = '0; rst = 1'b1; step(); rst = 1'b0;
    free_next = 1'b0; idx = 0;
    for (int j = 0; j < 6; j++) begin
      drive = (idx < 3) ? 4'b0010 : 4'b0000;
      data = '0; data[DW +: DW] = DW'(idx + 1);
      acc = drive[1] && (q[1].size() < D);
      step();
      if (acc) idx++;
    end
    check("bp_hold_data", 32'(data_r), 32'h1);
    check("bp_hold_vld",  32'(dn_r),   32'h1);
    check("bp_full",      32'(free_r[1]), 32'h0);
    drive = '0; free_next = 1'b1;
    step();
    check("bp_word2", 32'(data_r), 32'h2);
    step();
    check("bp_word3", 32'(data_r), 32'h3);
    step();
    check("bp_drain", 32'(dn_r), 32'h0);

    // Randomized traffic with occasional reset
    for (int j = 0; j < 200; j++) begin
      drive = 4'($urandom());
      data = 20'($urandom());
      free_next = ($urandom_range(0, 9) < 7);
      rst = ($urandom_range(0, 39) == 0);
      step();
    end
    rst = 1'b0;

    // Reset in the middle of buffered, stalled traffic
    drive = 4'b1111; free_next = 1'b0;
    for (int j = 0; j < 4; j++) begin
      data = 20'($urandom());
      step();
    end
    check("mid_busy", 32'(dn_r), 32'h1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_vld",  32'(dn_r),   32'h0);
    check("mid_rst_free", 32'(free_r), 32'hF);
    drive = '0; free_next = 1'b1;
    for (int j = 0; j < 5; j++) begin
      step();
      check("mid_no_stale_rr", 32'(dn_r), 32'h0);
      check("mid_no_stale_fx", 32'(dn_f), 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
